wired_fetch_queue: RTL and testbench
====================================

WIRED_FETCH_QUEUE -- requirements
Module: wired_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered fetch packets (power of two, 2..16).
REQ-002 SHALL have ports: clk  in  1  clock, all state rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flush_i  in  1  redirect/flush from backend correction, discards all buffered packets.
REQ-005 p_valid_i  in  1  packet offered by PC generator.
REQ-006 p_ready_o  out  1  queue accepts packet this cycle.
REQ-007 p_pc_i  in  32  fetch PC (8-byte aligned group base plus slot).
REQ-008 p_mask_i  in  2  per-slot valid mask.
REQ-009 p_predict_i  in  2 x bpu_predict_t  per-slot prediction metadata.
REQ-010 f_valid_o  out  1  head packet valid toward instruction-cache stage.
REQ-011 f_ready_i  in  1  cache stage consumes head this cycle.
REQ-012 f_pc_o, f_mask_o, f_predict_o  out  32 / 2 / 2 x bpu_predict_t  head packet fields.
REQ-013 count_o  out  clog2(DEPTH)+1  current occupancy, debug/perf.

Function
REQ-014 Push SHALL occur when p_valid_i && p_ready_o && !flush_i; pop SHALL occur when f_valid_o && f_ready_i && !flush_i.
REQ-015 p_ready_o SHALL equal (count < DEPTH), driven from registered state only (no combinational path from f_ready_i).
REQ-016 f_valid_o SHALL equal (count != 0); head fields SHALL be driven from storage, no input-to-output bypass: a packet pushed at edge N is visible on outputs after edge N.
REQ-017 Read/write pointers SHALL be clog2(DEPTH)+1 bits with wrap bit; full = MSBs differ and low bits equal; empty = pointers equal; increments wrap modulo 2*DEPTH.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; allowed whenever count in 1..DEPTH-1.
REQ-019 When full, no push occurs regardless of a same-cycle pop; the freed slot is usable next cycle.
REQ-020 When empty, f_valid_o=0 and f_ready_i is ignored; pointers unchanged.
REQ-021 flush_i SHALL reset both pointers to 0 and count to 0 at the next edge, overriding any same-cycle push or pop; f_valid_o=0 in the following cycle.
REQ-022 Packets with p_mask_i == 2'b00 SHALL be accepted and stored unchanged (no filtering).
REQ-023 Payload (pc, mask, predict) SHALL be stored bit-exact and emitted in FIFO order.
REQ-024 Output f_* payload fields while f_valid_o=0 are don't-care but SHALL not contain X after the first push.

Reset
REQ-025 On rst_n low, pointers and count SHALL clear to 0 immediately (async); f_valid_o=0, p_ready_o=1, count_o=0.
REQ-026 Payload storage SHALL not be reset; reset asserted mid-operation discards all packets and release resumes from empty.

Structure
REQ-027 bpu_predict_t and a packed fetch_pkt_t {pc, mask, predict[1:0]} SHALL live in the shared wired0_defines package.
REQ-028 Storage SHALL be a flop/LUT array of fetch_pkt_t inside the module; no sub-module.

Verification
REQ-029 Reset then push PC 0x1c000000, mask 2'b10 -> f_valid_o=1 next cycle, f_pc_o=0x1c000000, count_o=1.
REQ-030 Push 4 packets with f_ready_i=0 (DEPTH=4) -> p_ready_o=0 after 4th, 5th offer not accepted, pop order 0x1c000000,08,10,18.
REQ-031 Full queue, f_ready_i=1 and p_valid_i=1 same cycle -> one pop, no push, count_o=3, p_ready_o=1 next cycle.
REQ-032 Count=2, flush_i=1 with simultaneous push and pop -> count_o=0, f_valid_o=0 next cycle, pushed packet absent.
REQ-033 Continuous push/pop at count=1 for 20 cycles -> pointers wrap twice, payload order and predict fields bit-exact.
REQ-034 rst_n asserted mid-stream with count=3 -> f_valid_o=0 immediately, p_ready_o=1, first post-release push emerges first.

Source files
------------

// File: rtl/wired_fetch_queue_pkg.sv
// Shared front-end fetch types: per-slot branch prediction metadata and the
// fetch packet that flows from the PC generator to the instruction-cache stage.
package wired0_defines;

    localparam int FETCH_SLOTS = 2;

    typedef struct packed {
        logic        taken;
        logic [1:0]  br_type;
        logic [29:0] target;
    } bpu_predict_t;

    typedef struct packed {
        logic [31:0]                        pc;
        logic [FETCH_SLOTS-1:0]             mask;
        bpu_predict_t [FETCH_SLOTS-1:0]     predict;
    } fetch_pkt_t;

endpackage

// File: rtl/wired_fetch_queue.sv
// Fetch queue decoupling the PC generator from the instruction-cache stage.
// Wrap-bit pointers give full/empty without a separate counter register.
module wired_fetch_queue
    import wired0_defines::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         p_valid_i,
    output logic                         p_ready_o,
    input  logic [31:0]                  p_pc_i,
    input  logic [1:0]                   p_mask_i,
    input  bpu_predict_t [1:0]           p_predict_i,
    output logic                         f_valid_o,
    input  logic                         f_ready_i,
    output logic [31:0]                  f_pc_o,
    output logic [1:0]                   f_mask_o,
    output bpu_predict_t [1:0]           f_predict_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    fetch_pkt_t    mem [DEPTH];
    fetch_pkt_t    last_pkt;
    fetch_pkt_t    in_pkt;
    fetch_pkt_t    head_pkt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    assign p_ready_o = !full;
    assign f_valid_o = !empty;
    assign count_o   = wptr - rptr;

    assign push = p_valid_i && !full && !flush_i;
    assign pop  = !empty && f_ready_i && !flush_i;

    assign in_pkt = '{pc: p_pc_i, mask: p_mask_i, predict: p_predict_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // Payload is never reset; last_pkt keeps the idle outputs free of X
    // once anything has been written, even when rptr lands on a fresh slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= in_pkt;
            last_pkt          <= in_pkt;
        end
    end

    assign head_pkt = f_valid_o ? mem[rptr[AW-1:0]] : last_pkt;

    assign f_pc_o      = head_pkt.pc;
    assign f_mask_o    = head_pkt.mask;
    assign f_predict_o = head_pkt.predict;

endmodule

// File: tb/tb_wired_fetch_queue.sv
// Directed bench for wired_fetch_queue: a queue model predicts handshakes,
// occupancy and head payload every cycle.
module tb_wired_fetch_queue;
    import wired0_defines::*;

    localparam int DEPTH = 4;
    localparam int PRED_W = $bits(bpu_predict_t);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush_i = 1'b0;
    logic               p_valid_i = 1'b0;
    logic               p_ready_o;
    logic [31:0]        p_pc_i = '0;
    logic [1:0]         p_mask_i = '0;
    bpu_predict_t [1:0] p_predict_i = '0;
    logic               f_valid_o;
    logic               f_ready_i = 1'b0;
    logic [31:0]        f_pc_o;
    logic [1:0]         f_mask_o;
    bpu_predict_t [1:0] f_predict_o;
    logic [$clog2(DEPTH):0] count_o;

    int compared = 0;
    int mismatched = 0;
    fetch_pkt_t model_q[$];

    wired_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .p_pc_i(p_pc_i),
        .p_mask_i(p_mask_i), .p_predict_i(p_predict_i),
        .f_valid_o(f_valid_o), .f_ready_i(f_ready_i), .f_pc_o(f_pc_o),
        .f_mask_o(f_mask_o), .f_predict_o(f_predict_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bpu_predict_t [1:0] rand_pred();
        logic [63:0] r0, r1;
        bpu_predict_t [1:0] p;
        r0 = {$urandom(), $urandom()};
        r1 = {$urandom(), $urandom()};
        p[0] = r0[PRED_W-1:0];
        p[1] = r1[PRED_W-1:0];
        return p;
    endfunction

    // One cycle: drive at negedge, check outputs against the model, then
    // advance the model with the handshakes it predicts for the next edge.
    task automatic step(input logic pv, input logic [31:0] pc, input logic [1:0] mask,
                        input bpu_predict_t [1:0] pred, input logic fr, input logic fl,
                        input string tag);
        logic exp_valid, exp_ready, do_push, do_pop;
        fetch_pkt_t pkt;
        @(negedge clk);
        p_valid_i = pv; p_pc_i = pc; p_mask_i = mask; p_predict_i = pred;
        f_ready_i = fr; flush_i = fl;
        #1;
        exp_valid = (model_q.size() != 0);
        exp_ready = (model_q.size() < DEPTH);
        chk({tag, ".f_valid"}, 128'(f_valid_o), 128'(exp_valid));
        chk({tag, ".p_ready"}, 128'(p_ready_o), 128'(exp_ready));
        chk({tag, ".count"},   128'(count_o),   128'(model_q.size()));
        if (exp_valid) begin
            chk({tag, ".f_pc"},      128'(f_pc_o),      128'(model_q[0].pc));
            chk({tag, ".f_mask"},    128'(f_mask_o),    128'(model_q[0].mask));
            chk({tag, ".f_predict"}, 128'(f_predict_o), 128'(model_q[0].predict));
        end
        do_push = pv && exp_ready && !fl;
        do_pop  = exp_valid && fr && !fl;
        pkt = '{pc: pc, mask: mask, predict: pred};
        @(posedge clk);
        if (fl) model_q.delete();
        else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(pkt);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'h0, 2'b00, '0, 1'b0, 1'b0, tag);
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] mask, input string tag);
        step(1'b1, pc, mask, rand_pred(), 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++)
            step(1'b0, 32'h0, 2'b00, '0, 1'b1, 1'b0, tag);
        chk({tag, ".drained"}, 128'(model_q.size()), 128'(0));
    endtask

    initial begin
        // Asynchronous reset visible before any clock edge
        #1;
        chk("reset.f_valid", 128'(f_valid_o), 128'(0));
        chk("reset.p_ready", 128'(p_ready_o), 128'(1));
        chk("reset.count",   128'(count_o),   128'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // First packet visible after the push edge
        step(1'b1, 32'h1c000000, 2'b10, rand_pred(), 1'b0, 1'b0, "first_push");
        idle("first_visible");
        chk("first.pc", 128'(f_pc_o), 128'(32'h1c000000));
        chk("first.count", 128'(count_o), 128'(1));

        // Fill to full, fifth offer refused, mask 00 stored unchanged
        push(32'h1c000008, 2'b00, "fill1");
        push(32'h1c000010, 2'b01, "fill2");
        push(32'h1c000018, 2'b11, "fill3");
        push(32'h1c000020, 2'b11, "offer5");
        idle("full_hold");
        chk("full.p_ready", 128'(p_ready_o), 128'(0));
        drain("order");
        idle("empty_after_drain");
        chk("idle_no_x", 128'($isunknown({f_pc_o, f_mask_o, f_predict_o})), 128'(0));

        // Full plus same-cycle pop and push: only the pop happens
        push(32'h2000_0000, 2'b01, "f31a");
        push(32'h2000_0008, 2'b10, "f31b");
        push(32'h2000_0010, 2'b11, "f31c");
        push(32'h2000_0018, 2'b01, "f31d");
        step(1'b1, 32'h2000_0020, 2'b11, rand_pred(), 1'b1, 1'b0, "full_pop_push");
        idle("after_full_pop");
        chk("full_pop.count", 128'(count_o), 128'(3));
        chk("full_pop.p_ready", 128'(p_ready_o), 128'(1));
        drain("drain31");

        // Flush overrides simultaneous push and pop
        push(32'h3000_0000, 2'b01, "fl_a");
        push(32'h3000_0008, 2'b10, "fl_b");
        step(1'b1, 32'h3000_0010, 2'b11, rand_pred(), 1'b1, 1'b1, "flush");
        idle("after_flush");
        chk("flush.count", 128'(count_o), 128'(0));
        chk("flush.f_valid", 128'(f_valid_o), 128'(0));
        push(32'h3000_0018, 2'b11, "post_flush");
        drain("drain32");

        // Streaming at count 1 wraps the pointers several times
        push(32'h4000_0000, 2'b11, "stream_seed");
        for (int i = 1; i <= 20; i++)
            step(1'b1, 32'h4000_0000 + 32'(i * 8), 2'(i), rand_pred(), 1'b1, 1'b0, "stream");
        drain("drain33");

        // Reset mid-stream with three packets buffered
        push(32'h5000_0000, 2'b01, "rs_a");
        push(32'h5000_0008, 2'b10, "rs_b");
        push(32'h5000_0010, 2'b11, "rs_c");
        @(negedge clk);
        p_valid_i = 1'b0; f_ready_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.f_valid", 128'(f_valid_o), 128'(0));
        chk("midrst.p_ready", 128'(p_ready_o), 128'(1));
        chk("midrst.count",   128'(count_o),   128'(0));
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h5000_0100, 2'b10, "post_reset");
        idle("post_reset_head");
        chk("post_reset.pc", 128'(f_pc_o), 128'(32'h5000_0100));
        drain("drain34");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
